mod_n_counter: RTL and testbench
================================

# mod_n_counter

Free-running synchronous modulo-N up-counter. After reset it counts 0, 1, …, N-1 on successive clock edges, then wraps to 0 and repeats. Other blocks use it as a periodic sequence or timebase source: `dataout` is the count, and the two status outputs mark the terminal count and the wrap event. It has no enable or load input. It counts every cycle it is not in reset.

## Interface
- `N`, default 8: modulus, i.e. the number of distinct states. Legal range 2 ≤ N ≤ 2^`length`.
- `length`, default 3: width of `dataout` in bits. Must be at least ceil(log2(N)).
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `reset`, input, 1: reset is synchronous and active-high.
- `dataout`, output, `length`: current count value, registered.
- `tc`, output, 1: terminal-count flag. Combinational decode of `dataout == N-1`.
- `wrap`, output, 1: registered one-cycle pulse, high in the cycle where `dataout` has just wrapped from N-1 to 0.

## Operation
- Reset: on a rising `clk` edge with `reset`=1, `dataout` is set to 0 and `wrap` is set to 0. `reset` takes priority over counting.
- Count: on a rising edge with `reset`=0:
  - if `dataout` == N-1, then `dataout` is set to 0 and `wrap` is set to 1;
  - otherwise `dataout` is set to `dataout`+1 and `wrap` is set to 0.
- The comparison against N-1 is an explicit equality on the full `length`-bit value. There is no reliance on natural binary overflow, so non-power-of-2 N works.
- Out-of-range recovery: a value ≥ N can appear in `dataout` only through X or power-up state. If it does, the next non-reset edge loads 0. The counter must never dwell outside 0..N-1.
- `tc` = 1 exactly when `dataout` == N-1. It goes high one cycle before `wrap` pulses.
- Parameter check: elaboration must fail if N < 2, or if N > 2^`length`.
- Power-up: no initial value is guaranteed. `dataout`, `tc` and `wrap` are undefined until the first reset edge.

## Timing
- Latency from `reset` to output: `dataout`=0 and `wrap`=0 are visible right after the first rising edge that samples `reset`=1. Assertion or deassertion of `reset` between edges has no effect.
- First count: the first rising edge with `reset`=0 moves `dataout` from 0 to 1.
- Period: exactly N clock cycles per full sequence in steady state.
- `wrap` is high for exactly one cycle per period, aligned with `dataout`=0. It is not high during the reset-forced 0.
- `tc` changes only with `dataout`, as a combinational output with no added latency.
- Reset mid-count: at any count value, one reset edge forces 0. Counting resumes at 1 on the next non-reset edge.
- Reset held for several cycles: `dataout` stays at 0 and `wrap` stays at 0.

## Test plan
- Reset then free-run, with N=8, `length`=3 and a 10 ns clock:
  - stimulus: assert `reset` at the negedge at 10 ns, release it at the negedge at 20 ns, and run until 120 ns;
  - required response: `dataout` becomes 0 at 15 ns, then reads 1,2,3,4,5,6,7,0,1,2 at the posedges from 25 ns to 115 ns.
- Wrap and terminal count, N=8: `tc`=1 only while `dataout`=7. `wrap`=1 only in the cycle after 7→0, i.e. from the 95 ns edge until the 105 ns edge. Both stay 0 elsewhere.
- Non-power-of-2 modulus, N=5, `length`=3:
  - stimulus: reset, then 12 clocks;
  - required response: sequence 0,1,2,3,4,0,1,2,3,4,0,1,2; the values 5, 6 and 7 never appear; `wrap` pulses every 5 cycles.
- Mid-count reset, N=8: reset when `dataout`=5 → `dataout`=0 at the next edge with `wrap`=0. The next edge after release gives 1.
- Held reset: `reset`=1 for 4 cycles → `dataout` stays 0 and `wrap` stays 0 throughout. Release → 1, 2, …
- Full-width modulus, N=4, `length`=2: sequence 0,1,2,3,0 with a correct `wrap` pulse. Separately, elaborating with N=9, `length`=3 must be rejected.

Source files
------------

// File: rtl/mod_n_counter_if.sv
// Output bundle of the modulo-N counter: count value plus terminal-count
// and wrap status. The counter drives it through the master modport;
// consumers of the timebase attach through the slave modport.
interface mod_n_counter_if #(
  parameter int length = 3
);
  logic [length-1:0] dataout;
  logic              tc;
  logic              wrap;

  modport master (
    output dataout,
    output tc,
    output wrap
  );

  modport slave (
    input dataout,
    input tc,
    input wrap
  );
endinterface

// File: rtl/mod_n_counter.sv
// Free-running modulo-N up-counter used as a periodic sequence / timebase.
// Counts 0..N-1 and wraps to 0. tc decodes N-1 combinationally.
// wrap is a registered one-cycle pulse that coincides with the 0 that
// follows N-1. A value outside 0..N-1 (only reachable from X or power-up
// state) is replaced by 0 on the next non-reset edge. That replacement
// does not raise wrap, because no real N-1 -> 0 transition took place.
module mod_n_counter #(
  parameter int N      = 8,
  parameter int length = 3
) (
  input logic             clk,
  input logic             reset,
  mod_n_counter_if.master cnt_if
);

  // Reject moduli that cannot be represented or that are degenerate.
  if (length < 1) begin : g_bad_length
    $error("mod_n_counter: length must be at least 1");
  end
  if (N < 2) begin : g_bad_n_low
    $error("mod_n_counter: N must be at least 2");
  end
  if (longint'(N) > (longint'(1) << length)) begin : g_bad_n_high
    $error("mod_n_counter: N exceeds 2**length");
  end

  localparam logic [length-1:0] LAST = length'(N - 1);

  logic [length-1:0] dataout_q, dataout_d;
  logic              wrap_q, wrap_d;
  logic              at_last;
  logic              out_of_range;

  // Next-count decode. Equality on the full width means that a
  // non-power-of-2 N never relies on binary overflow.
  always_comb begin
    at_last      = (dataout_q == LAST);
    out_of_range = ({1'b0, dataout_q} > {1'b0, LAST});
    dataout_d    = dataout_q + length'(1);
    wrap_d       = 1'b0;
    if (at_last) begin
      dataout_d = '0;
      wrap_d    = 1'b1;
    end else if (out_of_range) begin
      dataout_d = '0;
    end
  end

  // Count and wrap registers. The synchronous reset overrides counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataout_q <= '0;
      wrap_q    <= 1'b0;
    end else begin
      dataout_q <= dataout_d;
      wrap_q    <= wrap_d;
    end
  end

  // Drive the output bundle. tc follows dataout with no added latency.
  always_comb begin
    cnt_if.dataout = dataout_q;
    cnt_if.tc      = at_last;
    cnt_if.wrap    = wrap_q;
  end

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed test of mod_n_counter in three configurations:
//   dut 0: N=8, length=3   dut 1: N=5, length=3   dut 2: N=4, length=2
// For each cycle the stimulus process drives reset at the negedge and
// pushes the hand-computed response for the following posedge. The
// monitor, running on its own, samples 1 ns after every posedge and
// checks the sample against the oldest queued entry.
module tb_mod_n_counter;

  logic clk;
  logic rst0, rst1, rst2;

  mod_n_counter_if #(.length(3)) if0 ();
  mod_n_counter_if #(.length(3)) if1 ();
  mod_n_counter_if #(.length(2)) if2 ();

  mod_n_counter #(.N(8), .length(3)) u_dut0 (.clk(clk), .reset(rst0), .cnt_if(if0));
  mod_n_counter #(.N(5), .length(3)) u_dut1 (.clk(clk), .reset(rst1), .cnt_if(if1));
  mod_n_counter #(.N(4), .length(2)) u_dut2 (.clk(clk), .reset(rst2), .cnt_if(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       dut;
    logic [3:0] d;
    logic     tc;
    logic     wr;
    int       idx;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_push = 0;

  // Drive reset for the selected DUT at the negedge and queue the response
  // required after the next posedge.
  task automatic vec(input int dut, input logic rst, input int d,
                     input logic tc, input logic wr);
    exp_t e;
    @(negedge clk);
    case (dut)
      0:       rst0 = rst;
      1:       rst1 = rst;
      default: rst2 = rst;
    endcase
    e.dut = dut;
    e.d   = 4'(d);
    e.tc  = tc;
    e.wr  = wr;
    e.idx = n_push;
    n_push++;
    sb_q.push_back(e);
  endtask

  // Monitor: every output cycle with a pending expectation is compared.
  initial begin
    exp_t       e;
    logic [3:0] act_d;
    logic       act_tc, act_wr;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        case (e.dut)
          0: begin
            act_d = {1'b0, if0.dataout}; act_tc = if0.tc; act_wr = if0.wrap;
          end
          1: begin
            act_d = {1'b0, if1.dataout}; act_tc = if1.tc; act_wr = if1.wrap;
          end
          default: begin
            act_d = {2'b0, if2.dataout}; act_tc = if2.tc; act_wr = if2.wrap;
          end
        endcase
        n_vec++;
        if (act_d !== e.d || act_tc !== e.tc || act_wr !== e.wr) begin
          n_miss++;
          $display("FAIL vec%0d dut%0d at %0t: got dataout=%0d tc=%b wrap=%b, want dataout=%0d tc=%b wrap=%b",
                   e.idx, e.dut, $time, act_d, act_tc, act_wr, e.d, e.tc, e.wr);
        end
      end
    end
  end

  initial begin
    rst0 = 1'b0;
    rst1 = 1'b1;
    rst2 = 1'b1;

    // N=8: reset at 10 ns, release at 20 ns, 1..7,0,1,2 from 25 to 115 ns.
    vec(0, 1, 0, 0, 0);
    vec(0, 0, 1, 0, 0);
    vec(0, 0, 2, 0, 0);
    vec(0, 0, 3, 0, 0);
    vec(0, 0, 4, 0, 0);
    vec(0, 0, 5, 0, 0);
    vec(0, 0, 6, 0, 0);
    vec(0, 0, 7, 1, 0);
    vec(0, 0, 0, 0, 1);
    vec(0, 0, 1, 0, 0);
    vec(0, 0, 2, 0, 0);
    // N=8 mid-count reset with dataout=5, then resume at 1.
    vec(0, 0, 3, 0, 0);
    vec(0, 0, 4, 0, 0);
    vec(0, 0, 5, 0, 0);
    vec(0, 1, 0, 0, 0);
    vec(0, 0, 1, 0, 0);
    // N=8 reset held for 4 cycles, then release.
    vec(0, 1, 0, 0, 0);
    vec(0, 1, 0, 0, 0);
    vec(0, 1, 0, 0, 0);
    vec(0, 1, 0, 0, 0);
    vec(0, 0, 1, 0, 0);
    vec(0, 0, 2, 0, 0);
    vec(0, 0, 3, 0, 0);
    vec(0, 0, 4, 0, 0);
    vec(0, 0, 5, 0, 0);
    vec(0, 0, 6, 0, 0);
    vec(0, 0, 7, 1, 0);
    // Reset while at N-1: forced 0 must not pulse wrap.
    vec(0, 1, 0, 0, 0);
    vec(0, 0, 1, 0, 0);
    vec(0, 0, 2, 0, 0);

    // N=5: reset, then 12 clocks; 5..7 never appear, wrap every 5 cycles.
    vec(1, 1, 0, 0, 0);
    vec(1, 0, 1, 0, 0);
    vec(1, 0, 2, 0, 0);
    vec(1, 0, 3, 0, 0);
    vec(1, 0, 4, 1, 0);
    vec(1, 0, 0, 0, 1);
    vec(1, 0, 1, 0, 0);
    vec(1, 0, 2, 0, 0);
    vec(1, 0, 3, 0, 0);
    vec(1, 0, 4, 1, 0);
    vec(1, 0, 0, 0, 1);
    vec(1, 0, 1, 0, 0);
    vec(1, 0, 2, 0, 0);

    // N=4, length=2: full-width modulus wraps by equality decode.
    vec(2, 1, 0, 0, 0);
    vec(2, 0, 1, 0, 0);
    vec(2, 0, 2, 0, 0);
    vec(2, 0, 3, 1, 0);
    vec(2, 0, 0, 0, 1);
    vec(2, 0, 1, 0, 0);
    vec(2, 0, 2, 0, 0);
    vec(2, 0, 3, 1, 0);
    vec(2, 0, 0, 0, 1);
    vec(2, 0, 1, 0, 0);

    // Let the monitor drain the queue, with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected responses never checked, want 0", sb_q.size());
    end
    if (n_vec != n_push) begin
      n_miss++;
      $display("FAIL count: %0d vectors checked, want %0d", n_vec, n_push);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
